// File: rtl/dmem_port_arbiter.sv
// Data-memory port arbiter: CPU load/store path vs debug/loader port.
// States: IDLE | no CPU read outstanding ; CPU_RD_WAIT | CPU read data returning this cycle.
module dmem_port_arbiter #(
    parameter int ADDR_W       = 14,
    parameter int DATA_W       = 32,
    parameter int CPU_PRIORITY = 1,
    parameter int STARVE_LIMIT = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,

    input  logic              cpu_req_i,
    input  logic              cpu_we_i,
    input  logic [ADDR_W-1:0] cpu_addr_i,
    input  logic [DATA_W-1:0] cpu_wdata_i,
    output logic              cpu_stall_o,
    output logic [DATA_W-1:0] cpu_rdata_o,
    output logic              cpu_rvalid_o,

    input  logic              dbg_req_i,
    input  logic              dbg_we_i,
    input  logic [ADDR_W-1:0] dbg_addr_i,
    input  logic [DATA_W-1:0] dbg_wdata_i,
    output logic              dbg_gnt_o,
    output logic [DATA_W-1:0] dbg_rdata_o,
    output logic              dbg_rvalid_o,

    output logic              mem_en_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i
);

    localparam logic [0:0] S_IDLE        = 1'b0;
    localparam logic [0:0] S_CPU_RD_WAIT = 1'b1;
    localparam logic [7:0] STARVE_LIM    = 8'(STARVE_LIMIT);

    logic [0:0] state_q, state_d;
    logic       dbg_rd_pend_q, dbg_rd_pend_d;
    logic [7:0] wait_cnt_q, wait_cnt_d;
    logic       last_gnt_q, last_gnt_d;

    logic cpu_elig;
    logic dbg_elig;
    logic gnt_cpu;
    logic gnt_dbg;

    // Nothing is eligible while reset is held, which forces every output low.
    assign cpu_elig = !rst_i && cpu_req_i && (state_q != S_CPU_RD_WAIT);
    assign dbg_elig = !rst_i && dbg_req_i;

    always_comb begin
        gnt_cpu = 1'b0;
        gnt_dbg = 1'b0;
        if (cpu_elig && dbg_elig) begin
            if (wait_cnt_q >= STARVE_LIM) begin
                gnt_dbg = 1'b1;
            end else if (CPU_PRIORITY != 0) begin
                gnt_cpu = 1'b1;
            end else if (last_gnt_q) begin
                gnt_cpu = 1'b1;
            end else begin
                gnt_dbg = 1'b1;
            end
        end else if (cpu_elig) begin
            gnt_cpu = 1'b1;
        end else if (dbg_elig) begin
            gnt_dbg = 1'b1;
        end
    end

    always_comb begin
        mem_en_o    = gnt_cpu || gnt_dbg;
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        if (gnt_cpu) begin
            mem_we_o    = cpu_we_i;
            mem_addr_o  = cpu_addr_i;
            mem_wdata_o = cpu_wdata_i;
        end else if (gnt_dbg) begin
            mem_we_o    = dbg_we_i;
            mem_addr_o  = dbg_addr_i;
            mem_wdata_o = dbg_wdata_i;
        end
    end

    assign cpu_stall_o  = cpu_elig && !(gnt_cpu && cpu_we_i);
    assign dbg_gnt_o    = gnt_dbg;
    assign cpu_rvalid_o = !rst_i && (state_q == S_CPU_RD_WAIT);
    assign dbg_rvalid_o = !rst_i && dbg_rd_pend_q;
    assign cpu_rdata_o  = cpu_rvalid_o ? mem_rdata_i : '0;
    assign dbg_rdata_o  = dbg_rvalid_o ? mem_rdata_i : '0;

    always_comb begin
        state_d       = (gnt_cpu && !cpu_we_i) ? S_CPU_RD_WAIT : S_IDLE;
        dbg_rd_pend_d = gnt_dbg && !dbg_we_i;
        wait_cnt_d    = 8'd0;
        if (dbg_req_i && !gnt_dbg) begin
            wait_cnt_d = (wait_cnt_q == 8'hFF) ? 8'hFF : wait_cnt_q + 8'd1;
        end
        last_gnt_d = last_gnt_q;
        if (gnt_dbg) begin
            last_gnt_d = 1'b1;
        end else if (gnt_cpu) begin
            last_gnt_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q       <= S_IDLE;
            dbg_rd_pend_q <= 1'b0;
            wait_cnt_q    <= 8'd0;
            last_gnt_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            dbg_rd_pend_q <= dbg_rd_pend_d;
            wait_cnt_q    <= wait_cnt_d;
            last_gnt_q    <= last_gnt_d;
        end
    end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench: fixed-priority and round-robin arbiters, each with its own synchronous-read memory.
module tb_dmem_port_arbiter;

    localparam int AW = 14;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          cpu_req, cpu_we, dbg_req, dbg_we;
    logic [AW-1:0] cpu_addr, dbg_addr;
    logic [DW-1:0] cpu_wdata, dbg_wdata;

    logic          cpu_stall_p, cpu_rvalid_p, dbg_gnt_p, dbg_rvalid_p, mem_en_p, mem_we_p;
    logic [DW-1:0] cpu_rdata_p, dbg_rdata_p, mem_wdata_p, mem_rdata_p;
    logic [AW-1:0] mem_addr_p;

    logic          cpu_stall_r, cpu_rvalid_r, dbg_gnt_r, dbg_rvalid_r, mem_en_r, mem_we_r;
    logic [DW-1:0] cpu_rdata_r, dbg_rdata_r, mem_wdata_r, mem_rdata_r;
    logic [AW-1:0] mem_addr_r;

    logic [DW-1:0] ram_p [0:(1<<AW)-1];
    logic [DW-1:0] ram_r [0:(1<<AW)-1];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    dmem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .CPU_PRIORITY(1), .STARVE_LIMIT(8)) u_pri (
        .clk_i(clk), .rst_i(rst),
        .cpu_req_i(cpu_req), .cpu_we_i(cpu_we), .cpu_addr_i(cpu_addr), .cpu_wdata_i(cpu_wdata),
        .cpu_stall_o(cpu_stall_p), .cpu_rdata_o(cpu_rdata_p), .cpu_rvalid_o(cpu_rvalid_p),
        .dbg_req_i(dbg_req), .dbg_we_i(dbg_we), .dbg_addr_i(dbg_addr), .dbg_wdata_i(dbg_wdata),
        .dbg_gnt_o(dbg_gnt_p), .dbg_rdata_o(dbg_rdata_p), .dbg_rvalid_o(dbg_rvalid_p),
        .mem_en_o(mem_en_p), .mem_we_o(mem_we_p), .mem_addr_o(mem_addr_p),
        .mem_wdata_o(mem_wdata_p), .mem_rdata_i(mem_rdata_p)
    );

    dmem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .CPU_PRIORITY(0), .STARVE_LIMIT(8)) u_rr (
        .clk_i(clk), .rst_i(rst),
        .cpu_req_i(cpu_req), .cpu_we_i(cpu_we), .cpu_addr_i(cpu_addr), .cpu_wdata_i(cpu_wdata),
        .cpu_stall_o(cpu_stall_r), .cpu_rdata_o(cpu_rdata_r), .cpu_rvalid_o(cpu_rvalid_r),
        .dbg_req_i(dbg_req), .dbg_we_i(dbg_we), .dbg_addr_i(dbg_addr), .dbg_wdata_i(dbg_wdata),
        .dbg_gnt_o(dbg_gnt_r), .dbg_rdata_o(dbg_rdata_r), .dbg_rvalid_o(dbg_rvalid_r),
        .mem_en_o(mem_en_r), .mem_we_o(mem_we_r), .mem_addr_o(mem_addr_r),
        .mem_wdata_o(mem_wdata_r), .mem_rdata_i(mem_rdata_r)
    );

    always @(posedge clk) begin
        if (mem_en_p) begin
            if (mem_we_p) ram_p[mem_addr_p] <= mem_wdata_p;
            mem_rdata_p <= ram_p[mem_addr_p];
        end
        if (mem_en_r) begin
            if (mem_we_r) ram_r[mem_addr_r] <= mem_wdata_r;
            mem_rdata_r <= ram_r[mem_addr_r];
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0;
        #3;
        check("rst_stall", cpu_stall_p, 0);
        check("rst_mem_en", mem_en_p, 0);
        check("rst_dbg_gnt", dbg_gnt_p, 0);
        check("rst_cpu_rvalid", cpu_rvalid_p, 0);
        next_cycle();
        rst = 1'b0; cpu_req = 1'b0; dbg_req = 1'b0;
        settle();
        check("idle_mem_en", mem_en_p, 0);

        // CPU write then read back
        next_cycle();
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 14'h010; cpu_wdata = 32'hDEADBEEF;
        settle();
        check("wr_mem_en", mem_en_p, 1);
        check("wr_mem_we", mem_we_p, 1);
        check("wr_mem_addr", mem_addr_p, 14'h010);
        check("wr_mem_wdata", mem_wdata_p, 32'hDEADBEEF);
        check("wr_stall", cpu_stall_p, 0);
        next_cycle();
        cpu_we = 1'b0;
        settle();
        check("rd1_stall", cpu_stall_p, 1);
        check("rd1_mem_en", mem_en_p, 1);
        check("rd1_mem_we", mem_we_p, 0);
        check("rd1_rvalid", cpu_rvalid_p, 0);
        next_cycle();
        settle();
        check("rd2_rvalid", cpu_rvalid_p, 1);
        check("rd2_rdata", cpu_rdata_p, 32'hDEADBEEF);
        check("rd2_stall", cpu_stall_p, 0);
        check("rd2_no_reissue", mem_en_p, 0);
        next_cycle();
        cpu_req = 1'b0;
        settle();
        check("rd3_rvalid", cpu_rvalid_p, 0);
        check("rd3_rdata_zero", cpu_rdata_p, 0);

        // Simultaneous CPU read and debug write, CPU priority
        next_cycle();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 14'h010;
        dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 14'h020; dbg_wdata = 32'h12345678;
        settle();
        check("sim1_mem_addr", mem_addr_p, 14'h010);
        check("sim1_dbg_gnt", dbg_gnt_p, 0);
        check("sim1_stall", cpu_stall_p, 1);
        next_cycle();
        settle();
        check("sim2_dbg_gnt", dbg_gnt_p, 1);
        check("sim2_mem_we", mem_we_p, 1);
        check("sim2_mem_addr", mem_addr_p, 14'h020);
        check("sim2_cpu_rvalid", cpu_rvalid_p, 1);
        check("sim2_cpu_rdata", cpu_rdata_p, 32'hDEADBEEF);
        check("sim2_stall", cpu_stall_p, 0);
        next_cycle();
        cpu_req = 1'b0; dbg_req = 1'b0;

        // Starvation guard: debug read of 0x020 forced through in cycle 9
        for (int k = 1; k <= 10; k++) begin
            next_cycle();
            cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 14'h030; cpu_wdata = 32'(k);
            dbg_req = (k <= 9); dbg_we = 1'b0; dbg_addr = 14'h020;
            settle();
            check($sformatf("starve_gnt_c%0d", k), dbg_gnt_p, (k == 9));
            check($sformatf("starve_stall_c%0d", k), cpu_stall_p, (k == 9));
            if (k == 9) check("starve_mem_addr", mem_addr_p, 14'h020);
            if (k == 10) begin
                check("starve_dbg_rvalid", dbg_rvalid_p, 1);
                check("starve_dbg_rdata", dbg_rdata_p, 32'h12345678);
            end
        end
        next_cycle();
        cpu_req = 1'b0; dbg_req = 1'b0;

        // Round-robin instance: CPU alone first, then both write continuously
        for (int k = 0; k <= 6; k++) begin
            next_cycle();
            cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 14'h040; cpu_wdata = 32'h100 + 32'(k);
            dbg_req = (k > 0); dbg_we = 1'b1; dbg_addr = 14'h050; dbg_wdata = 32'h200 + 32'(k);
            settle();
            check($sformatf("rr_gnt_c%0d", k), dbg_gnt_r, (k % 2 == 1));
            check($sformatf("rr_stall_c%0d", k), cpu_stall_r, (k % 2 == 1));
            check($sformatf("rr_addr_c%0d", k), mem_addr_r, (k % 2 == 1) ? 14'h050 : 14'h040);
            if (k == 6) begin
                check("rr_cpu_rvalid", cpu_rvalid_r, 0);
                check("rr_cpu_rdata", cpu_rdata_r, 0);
                check("rr_dbg_rvalid", dbg_rvalid_r, 0);
                check("rr_dbg_rdata", dbg_rdata_r, 0);
            end
        end
        next_cycle();
        cpu_req = 1'b0; dbg_req = 1'b0;

        // Debug burst: preload 0x000-0x003, then read them back-to-back
        for (int k = 0; k < 4; k++) begin
            next_cycle();
            dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = AW'(k); dbg_wdata = 32'hA0 + 32'(k);
            settle();
            check($sformatf("pre_gnt_%0d", k), dbg_gnt_p, 1);
        end
        for (int k = 0; k <= 4; k++) begin
            next_cycle();
            dbg_req = (k < 4); dbg_we = 1'b0; dbg_addr = AW'(k);
            settle();
            check($sformatf("burst_gnt_%0d", k), dbg_gnt_p, (k < 4));
            if (k > 0) begin
                check($sformatf("burst_rvalid_%0d", k), dbg_rvalid_p, 1);
                check($sformatf("burst_rdata_%0d", k), dbg_rdata_p, 32'hA0 + 32'(k - 1));
            end
        end
        next_cycle();
        dbg_req = 1'b0;
        settle();
        check("burst_rvalid_end", dbg_rvalid_p, 0);
        check("burst_rdata_end", dbg_rdata_p, 0);

        // Reset arriving while a CPU read is returning discards it
        next_cycle();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 14'h010;
        settle();
        check("rrst_issue_stall", cpu_stall_p, 1);
        next_cycle();
        rst = 1'b1;
        settle();
        check("rrst_rvalid", cpu_rvalid_p, 0);
        check("rrst_rdata", cpu_rdata_p, 0);
        check("rrst_stall", cpu_stall_p, 0);
        check("rrst_mem_en", mem_en_p, 0);
        next_cycle();
        rst = 1'b0; cpu_req = 1'b0;
        settle();
        check("rrst_post_rvalid", cpu_rvalid_p, 0);
        check("rrst_post_stall", cpu_stall_p, 0);
        next_cycle();
        cpu_req = 1'b1; cpu_we = 1'b0;
        settle();
        check("rrst_post_req_stall", cpu_stall_p, 1);
        check("rrst_post_req_en", mem_en_p, 1);
        next_cycle();
        cpu_req = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
